// File: rtl/mul32_seq_pkg.sv
// Shared definitions for the sequential 32x32 multiplier: state encoding,
// iteration constants and the adder-free counter increment.
package mul32_seq_pkg;

    localparam int WIDTH    = 32;
    localparam int MUL_ITER = 32;
    localparam int CNT_W    = 5;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_ITER - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ABSA  = 3'd1,
        ABSB  = 3'd2,
        MUL   = 3'd3,
        NEGLO = 3'd4,
        NEGHI = 3'd5,
        DONE  = 3'd6
    } state_t;

    // Toggle-chain increment so the iteration counter never touches the shared adder.
    function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
        logic [CNT_W-1:0] r;
        logic             carry;
        carry = 1'b1;
        for (int i = 0; i < CNT_W; i++) begin
            r[i]  = c[i] ^ carry;
            carry = carry & c[i];
        end
        return r;
    endfunction

endpackage

// File: rtl/mul32_seq_if.sv
// Request/result bundle between a requester (master) and the multiplier (slave).
interface mul32_seq_if;
    import mul32_seq_pkg::*;

    // start is a pulse honoured only while busy=0; a/b/sign are captured on that
    // same edge. done pulses for one cycle; hi/lo then hold until the next accepted start.
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sign;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, a, b, sign,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, a, b, sign,
        output busy, done, hi, lo
    );

endinterface

// File: rtl/mul32_seq_cla32.sv
// 32-bit carry-lookahead adder: 4-bit lookahead groups with group-level
// generate/propagate chained across the eight groups.
module cla32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        co
);
    logic [31:0] g;
    logic [31:0] p;
    logic [31:0] c;
    logic [7:0]  bg;
    logic [7:0]  bp;

    assign g = a & b;
    assign p = a ^ b;

    for (genvar k = 0; k < 8; k++) begin : g_grp
        assign bg[k] = g[4*k+3]
                     | (p[4*k+3] & g[4*k+2])
                     | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                     | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
        assign bp[k] = &p[4*k+3:4*k];
    end

    always_comb begin
        logic carry;
        c     = '0;
        carry = cin;
        for (int k = 0; k < 8; k++) begin
            c[4*k]   = carry;
            c[4*k+1] = g[4*k] | (p[4*k] & carry);
            c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k])
                     | (p[4*k+1] & p[4*k] & carry);
            c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1])
                     | (p[4*k+2] & p[4*k+1] & g[4*k])
                     | (p[4*k+2] & p[4*k+1] & p[4*k] & carry);
            carry    = bg[k] | (bp[k] & carry);
        end
        co = carry;
    end

    assign sum = p ^ c;

endmodule

// File: rtl/mul32_seq.sv
// Sequential shift-add multiplier: sign-magnitude conversion, 32 add/shift
// iterations and a two-cycle 64-bit negate, all through one shared cla32.
module mul32_seq
    import mul32_seq_pkg::*;
#(
    parameter int WIDTH = mul32_seq_pkg::WIDTH
) (
    input  logic              clk,
    input  logic              reset,
    mul32_seq_if.slave        bus,
    output state_t            dbg_state
);
    state_t           state;
    state_t           state_next;

    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic             sign_r;
    logic             neg;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] hi_r;
    logic [WIDTH-1:0] lo_r;
    logic [CNT_W-1:0] cnt;
    logic             cy;

    logic [WIDTH-1:0] add_x;
    logic [WIDTH-1:0] add_y;
    logic             add_cin;
    logic [WIDTH-1:0] add_sum;
    logic             add_co;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.start) state_next = ABSA;
            ABSA:    state_next = ABSB;
            ABSB:    state_next = MUL;
            MUL:     if (cnt == CNT_LAST) state_next = NEGLO;
            NEGLO:   state_next = NEGHI;
            NEGHI:   state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Operand selection depends on state alone; the register update decides
    // whether the sum is actually used.
    always_comb begin
        add_x   = '0;
        add_y   = '0;
        add_cin = 1'b0;
        case (state)
            ABSA: begin
                add_x   = ~a_r;
                add_cin = 1'b1;
            end
            ABSB: begin
                add_x   = ~b_r;
                add_cin = 1'b1;
            end
            MUL: begin
                add_x = hi_r;
                add_y = mcand;
            end
            NEGLO: begin
                add_x   = ~lo_r;
                add_cin = 1'b1;
            end
            NEGHI: begin
                add_x   = ~hi_r;
                add_cin = cy;
            end
            default: ;
        endcase
    end

    cla32 u_add (
        .a   (add_x),
        .b   (add_y),
        .cin (add_cin),
        .sum (add_sum),
        .co  (add_co)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            a_r    <= '0;
            b_r    <= '0;
            sign_r <= 1'b0;
            neg    <= 1'b0;
            mcand  <= '0;
            hi_r   <= '0;
            lo_r   <= '0;
            cnt    <= '0;
            cy     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_r    <= bus.a;
                        b_r    <= bus.b;
                        sign_r <= bus.sign;
                        neg    <= bus.sign & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                    end
                end
                ABSA: mcand <= (sign_r & a_r[WIDTH-1]) ? add_sum : a_r;
                ABSB: begin
                    lo_r <= (sign_r & b_r[WIDTH-1]) ? add_sum : b_r;
                    hi_r <= '0;
                    cnt  <= '0;
                end
                MUL: begin
                    // Carry-out becomes the new MSB so 2^31 magnitudes never overflow.
                    if (lo_r[0]) {hi_r, lo_r} <= {add_co, add_sum, lo_r[WIDTH-1:1]};
                    else         {hi_r, lo_r} <= {1'b0, hi_r, lo_r[WIDTH-1:1]};
                    cnt <= cnt_inc(cnt);
                end
                NEGLO: begin
                    if (neg) begin
                        lo_r <= add_sum;
                        cy   <= add_co;
                    end else begin
                        cy   <= 1'b0;
                    end
                end
                NEGHI: if (neg) hi_r <= add_sum;
                default: ;
            endcase
        end
    end

    assign bus.busy  = (state != IDLE);
    assign bus.done  = (state == DONE);
    assign bus.hi    = hi_r;
    assign bus.lo    = lo_r;
    assign dbg_state = state;

endmodule

// File: doc/mul32_seq.md
MUL32_SEQ -- requirements
Module: mul32_seq

Interface
REQ-001 Parameter: WIDTH, default 32, operand width; only 32 is supported.
REQ-002 clk  in  1  single clock; all state changes on its rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 start  in  1  request pulse; sampled only in IDLE.
REQ-005 a  in  32  multiplicand; captured on accepted start.
REQ-006 b  in  32  multiplier; captured on accepted start.
REQ-007 sign  in  1  1 = two's-complement operands, 0 = unsigned; captured on accepted start.
REQ-008 busy  out  1  high in every state except IDLE.
REQ-009 done  out  1  one-cycle pulse when the result is valid.
REQ-010 hi  out  32  upper product word.
REQ-011 lo  out  32  lower product word.

Function
REQ-012 The block SHALL compute the 64-bit product {hi,lo} = a*b, signed or unsigned per sign, using exactly one 32-bit adder instance time-shared across all states.
REQ-013 FSM states SHALL be IDLE, ABSA, ABSB, MUL, NEGLO, NEGHI, DONE.
REQ-014 IDLE: if start=1, the block SHALL latch a, b, sign, set neg = sign & (a[31]^b[31]), and go to ABSA; otherwise it stays in IDLE.
REQ-015 ABSA: the adder SHALL compute (~a_r + 0 + cin=1); mcand <= sum if sign & a[31], else a_r; go to ABSB.
REQ-016 ABSB: the adder SHALL compute (~b_r + 0 + 1); lo <= sum if sign & b[31], else b_r; hi <= 0; cnt <= 0; go to MUL.
REQ-017 MUL: if lo[0]=1, the adder SHALL compute (hi + mcand + 0) and {hi,lo} <= {co, sum, lo[31:1]}; else {hi,lo} <= {1'b0, hi, lo[31:1]}; cnt increments; after the 32nd iteration (cnt=31) go to NEGLO.
REQ-018 NEGLO: if neg, lo <= ~lo + 1 via the adder and cy <= co; else lo holds and cy <= 0; go to NEGHI.
REQ-019 NEGHI: if neg, hi <= ~hi + 0 + cy via the adder; else hi holds; go to DONE.
REQ-020 DONE: done=1 for this cycle only; next state IDLE.
REQ-021 Latency SHALL be fixed: done is high in the cycle following the 36th rising edge after the edge that accepted start, independent of operand values or sign.
REQ-022 start while busy, including in DONE, SHALL be ignored and SHALL NOT be queued.
REQ-023 hi/lo SHALL hold their final values from DONE until the next accepted start, and SHALL be undefined to the user while busy=1.
REQ-024 Magnitude of 0x80000000 SHALL be treated as unsigned 2^31; no overflow flag is produced.
REQ-025 Adder operand mux SHALL be selected purely by state; in IDLE and DONE the adder inputs SHALL be zero.

Reset
REQ-026 reset=1 SHALL force state IDLE, busy=0, done=0, hi=0, lo=0, cnt=0, cy=0, neg=0 at the next edge, regardless of the current state, and SHALL abort any operation in progress.
REQ-027 reset SHALL take priority over start in the same cycle.

Structure
REQ-028 The shared package SHALL hold the state encoding (3-bit), MUL_ITER=32, and the WIDTH constant.
REQ-029 The datapath SHALL instantiate the team's existing cla32 carry-lookahead adder as the only sub-module; no other adders or '+' operators are permitted.
REQ-030 The iteration counter SHALL be 5 bits wide and its increment SHALL NOT use the shared adder.

Verification
REQ-031 Unsigned: a=0xFFFFFFFF, b=0xFFFFFFFF, sign=0 -> hi=0xFFFFFFFE, lo=0x00000001, done exactly 36 edges after accept.
REQ-032 Signed mixed: a=0xFFFFFFFF (-1), b=1, sign=1 -> hi=0xFFFFFFFF, lo=0xFFFFFFFF; the same operands with sign=0 -> hi=0x00000000, lo=0xFFFFFFFF.
REQ-033 Signed corner: a=b=0x80000000, sign=1 -> hi=0x40000000, lo=0x00000000; a=0, b=0xFFFFFFFB, sign=1 -> hi=lo=0.
REQ-034 Handshake: a start pulse at cycles 5, 20 and DONE-cycle of the first operation, with a=3, b=7 -> only one result (lo=21, hi=0) and exactly one done pulse; busy is continuously high for 37 cycles.
REQ-035 Reset mid-op: assert reset at MUL iteration 10 -> next cycle busy=0, done=0, hi=lo=0; a new start (a=6, b=7) then yields lo=42 with normal latency.
REQ-036 Random: 10k random a/b/sign checked against a 64-bit reference model, with back-to-back starts issued the cycle after done.
